wb_script_master: RTL and testbench
===================================

// Module: wb_script_master
// PURPOSE
// Parametrised, scripted Wishbone classic master for Caravel user-project benches (Makerchip and cocotb).
// Applies a timed reset to the DUT, then replays a DEPTH-entry script of write/read/poll ops against
//   user_project_wrapper wbs_* ports. Checks masked read data and reports passed/failed plus error detail.
// PARAMETERS
// ADDR_W    32   address width
// DATA_W    32   data width; SEL_W = DATA_W/8
// DEPTH     16   script entries; IDX_W = $clog2(DEPTH)
// TIMEOUT   255  max cycles waiting for ack per access; also max poll attempts
// RST_HOLD  4    cycles dut_rst_o is held high after start
// PORTS
// wb_clk_i    in   1       clock
// wb_rst_i    in   1       synchronous, active-high reset
// start       in   1       pulse: begin run (ignored while busy)
// cfg_we      in   1       script write strobe (ignored while busy)
// cfg_idx     in   IDX_W   script entry index
// cfg_op      in   2       00 END, 01 WRITE, 10 READ, 11 POLL
// cfg_adr     in   ADDR_W  access address
// cfg_dat     in   DATA_W  write data / expected read data
// cfg_mask    in   DATA_W  compare mask (WRITE: sel = OR-reduce of each mask byte)
// dut_rst_o   out  1       reset to DUT wb_rst_i
// wbs_cyc_o   out  1       Wishbone cycle
// wbs_stb_o   out  1       Wishbone strobe
// wbs_we_o    out  1       write enable
// wbs_sel_o   out  SEL_W   byte selects
// wbs_adr_o   out  ADDR_W  address
// wbs_dat_o   out  DATA_W  write data
// wbs_ack_i   in   1       slave ack
// wbs_dat_i   in   DATA_W  slave read data
// busy        out  1       run in progress
// passed      out  1       sticky: run completed with no error
// failed      out  1       sticky: run aborted on error
// err_code    out  2       0 none, 1 ack timeout, 2 read mismatch, 3 poll exhausted
// err_idx     out  IDX_W   script index at failure
// last_rdata  out  DATA_W  data of most recent ack'd read
// BEHAVIOUR
// Reset: all outputs 0 except dut_rst_o=1; script RAM contents unaffected; FSM -> IDLE.
// FSM: IDLE -> RSTH (start) -> FETCH -> REQ -> CHECK -> FETCH/DONE_P/DONE_F.
// IDLE: busy=0; cfg_we writes entry cfg_idx. start clears passed/failed/err_*, idx=0, busy=1.
// RSTH: dut_rst_o=1 for exactly RST_HOLD cycles, then 0 for rest of run.
// FETCH (1 cyc): op END -> DONE_P; else latch entry, set adr/dat/we/sel, clear timeout counter.
// REQ: cyc=stb=1, outputs stable until ack sampled high; cycle after ack cyc=stb=0 (classic, no pipelining).
//   READ/POLL sel = all ones, we=0. Timeout counter increments each REQ cycle without ack.
//   Counter reaching TIMEOUT without ack -> DONE_F, err 1; ack on that same cycle wins (no error).
// CHECK (1 cyc): WRITE -> next. READ: (dat_i^exp)&mask !=0 -> DONE_F err 2.
//   POLL mismatch: attempt counter++; one idle cycle then re-issue REQ; attempts==TIMEOUT -> DONE_F err 3.
// Next: idx==DEPTH-1 -> DONE_P (implicit END), else idx+1 -> FETCH. No wrap-around.
// DONE_P: passed=1; DONE_F: failed=1, err_idx=idx; cyc/stb forced 0; busy=0; return IDLE.
// passed and failed never both 1. Reset mid-REQ: cyc/stb drop on the same edge; no further bus activity.
// last_rdata updates on every ack'd READ/POLL, including mismatches.
// TESTING
// WRITE 0x3000_0000<=0xDEAD_BEEF, READ same exp 0xDEAD_BEEF mask all ones, END -> passed=1, 2 bus cycles.
// Slave never acks -> failed=1, err_code=1, err_idx=0, cyc drops after TIMEOUT cycles.
// READ exp 0x0000_00FF mask 0xFF, slave returns 0x1234_56FF -> passed; returns 0x...FE -> err 2.
// POLL bit0, slave sets it on 3rd read -> exactly 3 reads, passed; never set -> err 3 after TIMEOUT reads.
// DEPTH WRITEs, no END -> DEPTH bus cycles, passed; start/cfg_we during run ignored.
// wb_rst_i asserted mid-REQ -> cyc/stb/busy 0 next edge, dut_rst_o=1; new start reruns script cleanly.

Source files
------------

// File: rtl/wb_script_master.sv
// Scripted Wishbone classic master: timed DUT reset, then replays a
// write/read/poll script and reports pass/fail with error detail.
module wb_script_master #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 255,
  parameter int RST_HOLD = 4,
  localparam int SEL_W = DATA_W / 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [1:0]        cfg_op,
  input  logic [ADDR_W-1:0] cfg_adr,
  input  logic [DATA_W-1:0] cfg_dat,
  input  logic [DATA_W-1:0] cfg_mask,
  output logic              dut_rst_o,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  output logic              wbs_we_o,
  output logic [SEL_W-1:0]  wbs_sel_o,
  output logic [ADDR_W-1:0] wbs_adr_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              wbs_ack_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              busy,
  output logic              passed,
  output logic              failed,
  output logic [1:0]        err_code,
  output logic [IDX_W-1:0]  err_idx,
  output logic [DATA_W-1:0] last_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [1:0] OP_END  = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_RD   = 2'd2;
  localparam logic [1:0] OP_POLL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RSTH, S_FETCH, S_REQ,
    S_CHECK, S_GAP, S_DONE_P, S_DONE_F
  } state_t;

  state_t r_state, w_next, w_adv;

  logic [1:0]        r_sop  [DEPTH];
  logic [ADDR_W-1:0] r_sadr [DEPTH];
  logic [DATA_W-1:0] r_sdat [DEPTH];
  logic [DATA_W-1:0] r_smsk [DEPTH];

  logic [IDX_W-1:0]  r_idx;
  logic [HW-1:0]     r_hold;
  logic [CW-1:0]     r_to;
  logic [CW-1:0]     r_att;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_f_op;
  logic [DATA_W-1:0] w_f_mask;
  logic [SEL_W-1:0]  w_sel_wr;
  logic              w_mis;
  logic              w_to_last;
  logic              w_att_last;
  logic              w_hold_done;
  logic              w_last_idx;

  assign w_f_op      = r_sop[r_idx];
  assign w_f_mask    = r_smsk[r_idx];
  assign w_mis       = |((r_rdata ^ wbs_dat_o) & r_mask);
  assign w_to_last   = (r_to == CW'(TIMEOUT - 1));
  assign w_att_last  = (r_att == CW'(TIMEOUT - 1));
  assign w_hold_done = (r_hold == HW'(RST_HOLD - 1));
  assign w_last_idx  = (r_idx == IDX_W'(DEPTH - 1));
  assign w_adv       = w_last_idx ? S_DONE_P : S_FETCH;

  always_comb begin
    w_sel_wr = '0;
    for (int b = 0; b < SEL_W; b++)
      w_sel_wr[b] = |w_f_mask[b*8 +: 8];
  end

  // Script RAM is writable only while idle and survives reset.
  always_ff @(posedge wb_clk_i) begin
    if (cfg_we && r_state == S_IDLE) begin
      r_sop[cfg_idx]  <= cfg_op;
      r_sadr[cfg_idx] <= cfg_adr;
      r_sdat[cfg_idx] <= cfg_dat;
      r_smsk[cfg_idx] <= cfg_mask;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RSTH;
      S_RSTH:  if (w_hold_done) w_next = S_FETCH;
      S_FETCH: w_next = (w_f_op == OP_END) ? S_DONE_P : S_REQ;
      S_REQ: begin
        if (wbs_ack_i)      w_next = S_CHECK;
        else if (w_to_last) w_next = S_DONE_F;
      end
      S_CHECK: begin
        unique case (r_op)
          OP_RD:   w_next = w_mis ? S_DONE_F : w_adv;
          OP_POLL: w_next = !w_mis     ? w_adv :
                            w_att_last ? S_DONE_F : S_GAP;
          default: w_next = w_adv;
        endcase
      end
      S_GAP:   w_next = S_REQ;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    wbs_cyc_o = (r_state == S_REQ);
    wbs_stb_o = (r_state == S_REQ);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_idx      <= '0;
      r_hold     <= '0;
      r_to       <= '0;
      r_att      <= '0;
      r_op       <= OP_END;
      r_mask     <= '0;
      r_rdata    <= '0;
      dut_rst_o  <= 1'b1;
      wbs_we_o   <= 1'b0;
      wbs_sel_o  <= '0;
      wbs_adr_o  <= '0;
      wbs_dat_o  <= '0;
      busy       <= 1'b0;
      passed     <= 1'b0;
      failed     <= 1'b0;
      err_code   <= 2'd0;
      err_idx    <= '0;
      last_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          busy      <= 1'b1;
          passed    <= 1'b0;
          failed    <= 1'b0;
          err_code  <= 2'd0;
          err_idx   <= '0;
          r_idx     <= '0;
          r_hold    <= '0;
          dut_rst_o <= 1'b1;
        end
        S_RSTH: begin
          r_hold <= r_hold + 1'b1;
          if (w_hold_done) dut_rst_o <= 1'b0;
        end
        S_FETCH: begin
          r_op      <= w_f_op;
          r_mask    <= w_f_mask;
          wbs_adr_o <= r_sadr[r_idx];
          wbs_dat_o <= r_sdat[r_idx];
          wbs_we_o  <= (w_f_op == OP_WR);
          wbs_sel_o <= (w_f_op == OP_WR) ? w_sel_wr : '1;
          r_to      <= '0;
          r_att     <= '0;
        end
        S_REQ: begin
          if (wbs_ack_i) begin
            r_rdata <= wbs_dat_i;
            if (r_op != OP_WR) last_rdata <= wbs_dat_i;
          end else if (w_to_last) begin
            err_code <= 2'd1;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_next == S_FETCH) r_idx <= r_idx + 1'b1;
          if (r_op == OP_RD && w_mis) err_code <= 2'd2;
          if (r_op == OP_POLL && w_mis) begin
            r_att <= r_att + 1'b1;
            if (w_att_last) err_code <= 2'd3;
          end
        end
        S_GAP: r_to <= '0;
        S_DONE_P: begin
          passed <= 1'b1;
          busy   <= 1'b0;
        end
        S_DONE_F: begin
          failed  <= 1'b1;
          err_idx <= r_idx;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_script_master.sv
// Bench for wb_script_master: random-latency memory/poll slave plus a
// script-level reference model of the expected run outcome.
module tb_wb_script_master;
  localparam int DEPTH = 16;
  localparam int TO    = 20;
  localparam int RH    = 4;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] POLL_A = 32'h3000_0100;
  localparam logic [31:0] HOLE_A = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [1:0]  cfg_op = '0;
  logic [31:0] cfg_adr = '0, cfg_dat = '0, cfg_mask = '0;
  logic        dut_rst, cyc, stb, we, busy, passed, failed;
  logic [3:0]  sel, err_idx;
  logic [1:0]  err_code;
  logic [31:0] adr, dat, last_rdata;
  logic        ack = 1'b0;
  logic [31:0] sdat = '0;

  always #5 clk = ~clk;

  wb_script_master #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
    .TIMEOUT(TO), .RST_HOLD(RH)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_op(cfg_op),
    .cfg_adr(cfg_adr), .cfg_dat(cfg_dat), .cfg_mask(cfg_mask),
    .dut_rst_o(dut_rst), .wbs_cyc_o(cyc), .wbs_stb_o(stb),
    .wbs_we_o(we), .wbs_sel_o(sel), .wbs_adr_o(adr),
    .wbs_dat_o(dat), .wbs_ack_i(ack), .wbs_dat_i(sdat),
    .busy(busy), .passed(passed), .failed(failed),
    .err_code(err_code), .err_idx(err_idx),
    .last_rdata(last_rdata)
  );

  // Slave: 16-word memory, a poll register, and a hole that never acks.
  logic [31:0] smem [16];
  int          s_wait = 0;
  int          s_preads = 0;
  int          poll_k = 3;
  logic [31:0] poll_hi = '0;

  function automatic logic [31:0] rd_poll(int nth);
    return {poll_hi[31:1], nth >= poll_k};
  endfunction

  always @(posedge clk) begin
    ack <= 1'b0;
    if (rst) begin
      s_wait <= 0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      if (start && !busy) s_preads <= 0;
      if (cyc && stb && !ack && adr[31:28] != 4'hE) begin
        if (s_wait == 0) begin
          ack    <= 1'b1;
          s_wait <= $urandom_range(0, 3);
          if (we) begin
            for (int b = 0; b < 4; b++)
              if (sel[b]) smem[adr[5:2]][8*b +: 8] <= dat[8*b +: 8];
          end else if (adr == POLL_A) begin
            s_preads <= s_preads + 1;
            sdat     <= rd_poll(s_preads + 1);
          end else begin
            sdat <= smem[adr[5:2]];
          end
        end else begin
          s_wait <= s_wait - 1;
        end
      end
    end
  end

  // Bus monitor: per-run counters and protocol violations.
  int          n_bus, n_cyc, n_rsth, n_bad;
  logic        p_req = 1'b0, p_ack = 1'b0;
  logic [68:0] p_sig = '0;

  always @(posedge clk) begin
    if (rst || (start && !busy)) begin
      n_bus <= 0; n_cyc <= 0; n_rsth <= 0; n_bad <= 0;
    end else begin
      if (cyc && stb && ack) n_bus <= n_bus + 1;
      if (cyc) n_cyc <= n_cyc + 1;
      if (busy && dut_rst) n_rsth <= n_rsth + 1;
      if ((p_req && cyc && stb && {adr, dat, we, sel} != p_sig) ||
          (p_ack && (cyc || stb)) || (cyc != stb))
        n_bad <= n_bad + 1;
    end
    p_req <= cyc && stb && !ack;
    p_ack <= cyc && stb && ack;
    p_sig <= {adr, dat, we, sel};
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, string nm, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, nm, obs, exp);
    end
  endtask

  // Testbench copy of the script and the reference model.
  logic [1:0]  s_op  [DEPTH];
  logic [31:0] s_adr [DEPTH];
  logic [31:0] s_dat [DEPTH];
  logic [31:0] s_msk [DEPTH];
  bit          e_fail;
  logic [1:0]  e_err;
  logic [3:0]  e_idx;
  int          e_bus;
  logic [31:0] e_last;
  logic [31:0] mdl_last = '0;

  task automatic model();
    logic [31:0] m [16];
    logic [31:0] d;
    int pr, att;
    bit done, ok;
    for (int i = 0; i < 16; i++) m[i] = smem[i];
    pr = 0; done = 0;
    e_fail = 0; e_err = 0; e_idx = 0; e_bus = 0; e_last = mdl_last;
    for (int i = 0; i < DEPTH && !done; i++) begin
      if (s_op[i] == 2'd0) begin
        done = 1;
      end else if (s_adr[i][31:28] == 4'hE) begin
        e_fail = 1; e_err = 1; e_idx = 4'(i); done = 1;
      end else if (s_op[i] == 2'd1) begin
        e_bus++;
        for (int b = 0; b < 4; b++)
          if (|s_msk[i][8*b +: 8])
            m[s_adr[i][5:2]][8*b +: 8] = s_dat[i][8*b +: 8];
      end else begin
        ok = 0; att = 0;
        while (!ok && !done) begin
          if (s_adr[i] == POLL_A) begin pr++; d = rd_poll(pr); end
          else d = m[s_adr[i][5:2]];
          e_bus++;
          e_last = d;
          if (((d ^ s_dat[i]) & s_msk[i]) == 32'h0) ok = 1;
          else if (s_op[i] == 2'd2) begin
            e_fail = 1; e_err = 2; e_idx = 4'(i); done = 1;
          end else begin
            att++;
            if (att == TO) begin
              e_fail = 1; e_err = 3; e_idx = 4'(i); done = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic prog(int i, logic [1:0] op, logic [31:0] a, logic [31:0] d, logic [31:0] m);
    s_op[i] = op; s_adr[i] = a; s_dat[i] = d; s_msk[i] = m;
    cfg_idx = 4'(i); cfg_op = op; cfg_adr = a; cfg_dat = d; cfg_mask = m;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_script();
    for (int i = 0; i < DEPTH; i++) prog(i, 2'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic run(string tag, bit poke);
    int n;
    n = 0;
    model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 6000) begin
      if (poke && n == 10) begin
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd5; cfg_op = 2'd0;
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; cfg_we = 1'b0;
    chk(tag, "busy", busy, 0);
    chk(tag, "passed", passed, !e_fail);
    chk(tag, "failed", failed, e_fail);
    chk(tag, "err_code", err_code, e_err);
    chk(tag, "err_idx", err_idx, e_idx);
    chk(tag, "nbus", n_bus, e_bus);
    chk(tag, "last_rdata", last_rdata, e_last);
    chk(tag, "rst_hold", n_rsth, RH);
    chk(tag, "protocol", n_bad, 0);
    chk(tag, "dut_rst", dut_rst, 0);
    mdl_last = e_last;
  endtask

  initial begin
    int n, op;
    bit found;
    logic [31:0] a;
    poll_hi = $urandom;
    repeat (3) @(negedge clk);
    chk("rst", "dut_rst", dut_rst, 1);
    chk("rst", "busy", busy, 0);
    chk("rst", "pf", {passed, failed}, 0);
    chk("rst", "bus", {cyc, stb, we, sel}, 0);
    chk("rst", "adrdat", {adr, dat}, 0);
    chk("rst", "err", {err_code, err_idx}, 0);
    chk("rst", "last", last_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    clear_script();
    prog(0, 2'd1, BASE, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    prog(1, 2'd2, BASE, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    run("wr_rd", 0);
    chk("wr_rd", "nbus2", n_bus, 2);

    clear_script();
    prog(0, 2'd2, HOLE_A, 32'h0, 32'hFFFF_FFFF);
    run("timeout", 0);
    chk("timeout", "cyc_len", n_cyc, TO);

    clear_script();
    prog(0, 2'd1, BASE + 8, 32'h1234_56FF, 32'hFFFF_FFFF);
    prog(1, 2'd2, BASE + 8, 32'h0000_00FF, 32'h0000_00FF);
    run("mask_ok", 0);
    prog(0, 2'd1, BASE + 8, 32'h1234_56FE, 32'hFFFF_FFFF);
    run("mask_bad", 0);
    chk("mask_bad", "code2", err_code, 2);

    clear_script();
    poll_k = 3;
    prog(0, 2'd3, POLL_A, 32'h1, 32'h1);
    run("poll3", 0);
    chk("poll3", "reads", n_bus, 3);
    poll_k = 1000;
    run("poll_ex", 0);
    chk("poll_ex", "reads", n_bus, TO);

    for (int i = 0; i < DEPTH; i++)
      prog(i, 2'd1, BASE + 32'(4 * i), $urandom, $urandom);
    run("full", 1);
    chk("full", "depth", n_bus, DEPTH);
    run("full_again", 0);

    clear_script();
    prog(0, 2'd1, BASE + 12, $urandom, 32'hFFFF_FFFF);
    prog(1, 2'd2, HOLE_A, 32'h0, 32'hFFFF_FFFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0; n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      found = cyc && (adr == HOLE_A);
    end
    chk("midrst", "reach", found, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst", "bus", {cyc, stb, busy}, 0);
    chk("midrst", "dut_rst", dut_rst, 1);
    chk("midrst", "pf", {passed, failed}, 0);
    rst = 1'b0;
    mdl_last = '0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(cyc | stb | busy);
    end
    chk("midrst", "quiet", n, 0);
    run("rerun", 0);

    for (int r = 0; r < 6; r++) begin
      poll_k = $urandom_range(1, TO + 2);
      for (int i = 0; i < DEPTH; i++) begin
        op = $urandom_range(0, 19);
        a = BASE + 32'(4 * $urandom_range(0, 15));
        if ($urandom_range(0, 24) == 0) a = HOLE_A;
        if (op == 0)
          prog(i, 2'd0, 32'h0, 32'h0, 32'h0);
        else if (op < 9)
          prog(i, 2'd1, a, $urandom, $urandom);
        else if (op < 15)
          prog(i, 2'd2, a, $urandom,
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'h0);
        else
          prog(i, 2'd3, (a == HOLE_A) ? a : POLL_A, 32'h1, 32'h1);
      end
      run($sformatf("rand%0d", r), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
